// File: rtl/ripple_carry_adder_if.sv
// Operand/result bundle for the ripple-carry adder/subtractor.
// The master drives operands and the add/sub select; the slave returns the registered result and flags.
interface ripple_carry_adder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             subEn;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output a,
        output b,
        output subEn,
        input  result,
        input  cout,
        input  ovf
    );

    modport slave (
        input  a,
        input  b,
        input  subEn,
        output result,
        output cout,
        output ovf
    );
endinterface

// File: rtl/ripple_carry_adder.sv
// Registered ripple-carry adder/subtractor built from a chain of 1-bit full-adder cells.
// Subtraction is a + ~b + 1: B is inverted per bit and subEn feeds the carry-in of cell 0.
module rca_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ripple_carry_adder_if.slave   bus
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;

    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;
    logic             cout_reg;
    logic             cout_next;
    logic             ovf_reg;
    logic             ovf_next;

    assign carry[0] = bus.subEn;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign b_eff[gi] = bus.b[gi] ^ bus.subEn;

            rca_full_adder u_fa (
                .a    (bus.a[gi]),
                .b    (b_eff[gi]),
                .cin  (carry[gi]),
                .s    (sum[gi]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_comb begin
        result_next = sum;
        cout_next   = carry[WIDTH];
        ovf_next    = carry[WIDTH] ^ carry[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            result_reg <= result_next;
            cout_reg   <= cout_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign bus.result = result_reg;
    assign bus.cout   = cout_reg;
    assign bus.ovf    = ovf_reg;
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench: table-driven vectors plus hand sequences, checked through an expected-value queue.
module tb_ripple_carry_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ripple_carry_adder_if #(.WIDTH(32)) bus ();
    ripple_carry_adder_if #(.WIDTH(8))  bus8 ();

    ripple_carry_adder #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    ripple_carry_adder #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        ov;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        r;
        logic [31:0] res;
        logic        co;
        logic        ov;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(string name, logic [31:0] a, logic [31:0] b, logic sub, logic r,
                                logic [31:0] res, logic co, logic ov);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.sub = sub; v.r = r;
        v.res = res; v.co = co; v.ov = ov;
        return v;
    endfunction

    // Independent reference: wide arithmetic and sign-bit rules.
    function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic sub);
        exp_t        e;
        logic [32:0] wide;
        if (sub)
            wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
        else
            wide = {1'b0, a} + {1'b0, b};
        e.res = wide[31:0];
        e.co  = wide[32];
        if (sub)
            e.ov = (a[31] != b[31]) && (e.res[31] != a[31]);
        else
            e.ov = (a[31] == b[31]) && (e.res[31] != a[31]);
        return e;
    endfunction

    task automatic cmp(string name, string field, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s.%s: got %h, required %h", name, field, got, want);
        end
    endtask

    // Drive one operation just after an edge, queue its expectation, compare after the next edge.
    task automatic step(string name, logic [31:0] a, logic [31:0] b, logic sub, logic r, exp_t e);
        exp_t got_e;
        bus.a     = a;
        bus.b     = b;
        bus.subEn = sub;
        rst       = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s.queue: got empty, required 1 entry", name);
        end else begin
            got_e = exp_q.pop_front();
            n_checks--;
            n_checks++;
            if ($signed(bus.result) !== $signed(got_e.res)) begin
                n_fail++;
                $display("FAIL %s.result: got %h, required %h", name, bus.result, got_e.res);
            end
            cmp(name, "cout", {31'd0, bus.cout}, {31'd0, got_e.co});
            cmp(name, "ovf",  {31'd0, bus.ovf},  {31'd0, got_e.ov});
        end
        $display("txn %-14s a=%h b=%h sub=%0d rst=%0d -> result=%h cout=%0d ovf=%0d",
                 name, a, b, sub, r, bus.result, bus.cout, bus.ovf);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t        e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        bus.a = '0; bus.b = '0; bus.subEn = 1'b0;
        bus8.a = 8'h7F; bus8.b = 8'h01; bus8.subEn = 1'b0;

        vecs.push_back(mk("rst0",      32'hFFFFFFFF, 32'h1,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0));
        vecs.push_back(mk("rst1",      32'hFFFFFFFF, 32'h1,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0));
        vecs.push_back(mk("release",   32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0));
        vecs.push_back(mk("add5_7",    32'd5,        32'd7,        1'b0, 1'b0, 32'd12,       1'b0, 1'b0));
        vecs.push_back(mk("addwrap",   32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, 32'h0,        1'b1, 1'b0));
        vecs.push_back(mk("sub7_5",    32'd7,        32'd5,        1'b1, 1'b0, 32'd2,        1'b1, 1'b0));
        vecs.push_back(mk("sub5_7",    32'd5,        32'd7,        1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0));
        vecs.push_back(mk("sub0_0",    32'd0,        32'd0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0));
        vecs.push_back(mk("maxpos+1",  32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1));
        vecs.push_back(mk("minneg-1",  32'h80000000, 32'h1,        1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1));
        vecs.push_back(mk("0-minneg",  32'h0,        32'h80000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1));
        vecs.push_back(mk("pipe100+200", 32'd100,    32'd200,      1'b0, 1'b0, 32'd300,      1'b0, 1'b0));
        vecs.push_back(mk("pipe100-200", 32'd100,    32'd200,      1'b1, 1'b0, 32'hFFFFFF9C, 1'b0, 1'b0));
        vecs.push_back(mk("pipe_rst",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0));
        vecs.push_back(mk("pipe-1+-1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            e.res = vecs[i].res; e.co = vecs[i].co; e.ov = vecs[i].ov;
            step(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].r, e);
        end

        // Mid-cycle input changes must not reach the outputs before the next edge.
        e.res = 32'd30; e.co = 1'b0; e.ov = 1'b0;
        step("hold10+20", 32'd10, 32'd20, 1'b0, 1'b0, e);
        bus.a = 32'hDEADBEEF; bus.b = 32'h12345678; bus.subEn = 1'b1;
        #3;
        cmp("hold_midcycle", "result", bus.result, 32'd30);
        step("after_hold", 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0, model(32'hDEADBEEF, 32'h12345678, 1'b1));

        // subEn toggling every cycle.
        step("tog_add", 32'd9, 32'd4, 1'b0, 1'b0, model(32'd9, 32'd4, 1'b0));
        step("tog_sub", 32'd9, 32'd4, 1'b1, 1'b0, model(32'd9, 32'd4, 1'b1));
        step("tog_add2", 32'd9, 32'd4, 1'b0, 1'b0, model(32'd9, 32'd4, 1'b0));

        for (int i = 0; i < 32; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 32'h80000000; rb = 32'h80000000; rs = 1'b0; end
            step($sformatf("rand%0d", i), ra, rb, rs, 1'b0, model(ra, rb, rs));
        end

        // 8-bit instance has held 0x7F + 0x01 since reset released.
        cmp("w8_add", "result", {24'd0, bus8.result}, 32'h80);
        cmp("w8_add", "ovf",    {31'd0, bus8.ovf},    32'd1);
        cmp("w8_add", "cout",   {31'd0, bus8.cout},   32'd0);
        $display("txn w8_add         a=7f b=01 sub=0 -> result=%h cout=%0d ovf=%0d",
                 bus8.result, bus8.cout, bus8.ovf);
        bus8.a = 8'h80; bus8.b = 8'h01; bus8.subEn = 1'b1;
        @(posedge clk);
        #1;
        cmp("w8_sub", "result", {24'd0, bus8.result}, 32'h7F);
        cmp("w8_sub", "ovf",    {31'd0, bus8.ovf},    32'd1);
        cmp("w8_sub", "cout",   {31'd0, bus8.cout},   32'd1);
        $display("txn w8_sub         a=80 b=01 sub=1 -> result=%h cout=%0d ovf=%0d",
                 bus8.result, bus8.cout, bus8.ovf);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d entries, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
